// File: rtl/cnn_ctrl_pkg.sv
// Shared types and opcode layout helpers for the CNN layer controller.
package cnn_ctrl_pkg;

    // Layer operating modes carried in opcode bits [2:0].
    typedef enum logic [2:0] {
        MODE_NOP          = 3'b000,
        MODE_CONV         = 3'b001,
        MODE_CONV_POOL    = 3'b010,
        MODE_FC           = 3'b011,
        MODE_ILL4         = 3'b100,
        MODE_ILL5         = 3'b101,
        MODE_CONV_POOL_FC = 3'b110,
        MODE_FLUSH        = 3'b111
    } mode_e;

    // Layer sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_FILL   = 3'd2,
        ST_CONV   = 3'd3,
        ST_POOL   = 3'd4,
        ST_FC     = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Opcode layout: [2:0] mode, then n_filt, then n_elem in the MSBs.
    localparam int OP_MODE_LSB  = 0;
    localparam int OP_MODE_W    = 3;
    localparam int OP_NFILT_LSB = OP_MODE_LSB + OP_MODE_W;

    function automatic int op_nelem_lsb(input int filt_w);
        return OP_NFILT_LSB + filt_w;
    endfunction

    function automatic int op_width(input int filt_w, input int elem_w);
        return OP_MODE_W + filt_w + elem_w;
    endfunction

    // Modes that run the weight load / fill / convolution pipeline.
    function automatic logic mode_is_conv(input mode_e m);
        return (m == MODE_CONV) || (m == MODE_CONV_POOL) || (m == MODE_CONV_POOL_FC);
    endfunction

    function automatic logic mode_is_legal(input mode_e m);
        return (m != MODE_ILL4) && (m != MODE_ILL5);
    endfunction

endpackage

// File: rtl/cnn_weight_loader.sv
// Weight buffering sequencer: counts accepted beats into elements per filter
// and walks a one-hot write enable across the filters of the layer.
module cnn_weight_loader
    import cnn_ctrl_pkg::*;
#(
    parameter int NUM_FILTERS   = 32,
    parameter int MAX_ELEMS     = 63,
    parameter int ELEM_PER_BEAT = 2,
    localparam int FILT_W = $clog2(NUM_FILTERS + 1),
    localparam int ELEM_W = $clog2(MAX_ELEMS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   active,
    input  logic [FILT_W-1:0]      n_filt,
    input  logic [ELEM_W-1:0]      n_elem,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    output logic [NUM_FILTERS-1:0] weight_en_o,
    output logic                   load_done
);

    // Four spare bits so e + ELEM_PER_BEAT can never wrap.
    localparam int E_W = ELEM_W + 4;

    logic [FILT_W-1:0] f_reg, f_next;
    logic [E_W-1:0]    e_reg, e_next;
    logic [E_W-1:0]    e_sum;
    logic              beat;
    logic              filt_complete;

    // Beat accounting; counters are held at zero whenever loading is inactive.
    always_comb begin
        beat          = active && w_valid_i;
        e_sum         = e_reg + E_W'(ELEM_PER_BEAT);
        filt_complete = beat && (e_sum >= {4'b0000, n_elem});
        load_done     = filt_complete && (f_reg == n_filt - FILT_W'(1));
        f_next        = f_reg;
        e_next        = e_reg;
        if (!active) begin
            f_next = '0;
            e_next = '0;
        end else if (filt_complete) begin
            // Surplus elements of a partial final beat are dropped here.
            f_next = f_reg + FILT_W'(1);
            e_next = '0;
        end else if (beat) begin
            e_next = e_sum;
        end
    end

    // Filter and element counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_reg <= '0;
            e_reg <= '0;
        end else begin
            f_reg <= f_next;
            e_reg <= e_next;
        end
    end

    assign w_ready_o = active;

    // One-hot enable for the filter currently being written.
    for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_wen
        assign weight_en_o[gi] = active && (f_reg == FILT_W'(gi));
    end

endmodule

// File: rtl/cnn_layer_ctrl.sv
// CNN layer controller: sequences weight load, image pre-fill, convolution,
// optional pooling and optional FC for one layer per accepted start.
module cnn_layer_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int NUM_FILTERS     = 32,
    parameter int MAX_ELEMS       = 63,
    parameter int ELEM_PER_BEAT   = 2,
    parameter int IMG_FILL_CYCLES = 68,
    parameter int POOL_LEAD       = 16,
    localparam int FILT_W = $clog2(NUM_FILTERS + 1),
    localparam int ELEM_W = $clog2(MAX_ELEMS + 1),
    localparam int OP_W   = op_width(FILT_W, ELEM_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [OP_W-1:0]        op_code_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    output logic [NUM_FILTERS-1:0] weight_en_o,
    output logic                   pu_en_o,
    output logic                   conv_ctrl_o,
    output logic                   pool_ctrl_o,
    output logic                   fc_ctrl_o,
    input  logic                   pu_finish_i,
    input  logic                   conv_finish_i,
    input  logic                   pool_finish_i,
    input  logic                   fc_finish_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int NELEM_LSB = op_nelem_lsb(FILT_W);
    localparam int FILL_W    = $clog2(IMG_FILL_CYCLES + 1);
    localparam int LEAD_W    = $clog2(POOL_LEAD + 1);

    state_e            state_reg, state_next;
    mode_e             mode_reg;
    logic [FILT_W-1:0] nfilt_reg;
    logic [ELEM_W-1:0] nelem_reg;
    logic [FILL_W-1:0] fill_cnt_reg;
    logic [LEAD_W-1:0] lead_cnt_reg;
    logic              pu_done_reg, conv_done_reg;
    logic              err_reg;

    mode_e             start_mode;
    logic [FILT_W-1:0] start_nfilt;
    logic [ELEM_W-1:0] start_nelem;
    logic              start_acc;
    logic              start_bad;
    logic              in_conv;
    logic              load_done;

    // Opcode decode and start qualification; abort overrides a coincident start.
    always_comb begin
        start_mode  = mode_e'(op_code_i[OP_MODE_LSB +: OP_MODE_W]);
        start_nfilt = op_code_i[OP_NFILT_LSB +: FILT_W];
        start_nelem = op_code_i[NELEM_LSB +: ELEM_W];
        start_acc   = start_i && (state_reg == ST_IDLE) && !abort_i;
        start_bad   = !mode_is_legal(start_mode)
                    || (mode_is_conv(start_mode)
                        && ((start_nfilt == '0)
                            || (start_nfilt > FILT_W'(NUM_FILTERS))
                            || (start_nelem == '0)))
                    || (start_nelem > ELEM_W'(MAX_ELEMS));
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state_reg;
        in_conv    = (state_reg == ST_CONV) || (state_reg == ST_POOL);

        case (state_reg)
            ST_IDLE: begin
                if (start_acc && !start_bad) begin
                    case (start_mode)
                        MODE_CONV, MODE_CONV_POOL, MODE_CONV_POOL_FC: state_next = ST_LOAD_W;
                        MODE_FC:                                      state_next = ST_FC;
                        MODE_FLUSH:                                   state_next = ST_DONE;
                        default:                                      state_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD_W: begin
                if (load_done) state_next = ST_FILL;
            end
            ST_FILL: begin
                if (fill_cnt_reg == FILL_W'(IMG_FILL_CYCLES - 1)) state_next = ST_CONV;
            end
            ST_CONV: begin
                if (mode_reg == MODE_CONV) begin
                    // A finish that arrived before CONV is remembered by the flag.
                    if (conv_finish_i || conv_done_reg) state_next = ST_DONE;
                end else if (lead_cnt_reg == LEAD_W'(POOL_LEAD - 1)) begin
                    state_next = ST_POOL;
                end
            end
            ST_POOL: begin
                if (pool_finish_i)
                    state_next = (mode_reg == MODE_CONV_POOL_FC) ? ST_FC : ST_DONE;
            end
            ST_FC: begin
                if (fc_finish_i) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        if (abort_i) state_next = ST_IDLE;

        busy_o      = (state_reg != ST_IDLE);
        done_o      = (state_reg == ST_DONE);
        err_o       = err_reg;
        // Engine enables drop in the very cycle their finish is seen.
        pu_en_o     = (state_reg == ST_FILL) || (in_conv && !(pu_done_reg || pu_finish_i));
        conv_ctrl_o = in_conv && !(conv_done_reg || conv_finish_i);
        pool_ctrl_o = (state_reg == ST_POOL);
        fc_ctrl_o   = (state_reg == ST_FC);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Opcode fields held for the whole layer, captured on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg  <= MODE_NOP;
            nfilt_reg <= '0;
            nelem_reg <= '0;
        end else if (start_acc) begin
            mode_reg  <= start_mode;
            nfilt_reg <= start_nfilt;
            nelem_reg <= start_nelem;
        end
    end

    // Fill and pool-lead counters run only while in their own state.
    always_ff @(posedge clk) begin
        if (rst || (state_reg != ST_FILL)) fill_cnt_reg <= '0;
        else                               fill_cnt_reg <= fill_cnt_reg + FILL_W'(1);
        if (rst || (state_reg != ST_CONV)) lead_cnt_reg <= '0;
        else                               lead_cnt_reg <= lead_cnt_reg + LEAD_W'(1);
    end

    // Sticky engine-finish flags, live only while a layer is active.
    always_ff @(posedge clk) begin
        if (rst || (state_reg == ST_IDLE) || (state_reg == ST_DONE)) begin
            pu_done_reg   <= 1'b0;
            conv_done_reg <= 1'b0;
        end else begin
            if (pu_finish_i)   pu_done_reg   <= 1'b1;
            if (conv_finish_i) conv_done_reg <= 1'b1;
        end
    end

    // Rejected-start pulse, one cycle after the start.
    always_ff @(posedge clk) begin
        if (rst) err_reg <= 1'b0;
        else     err_reg <= start_acc && start_bad;
    end

    cnn_weight_loader #(
        .NUM_FILTERS   (NUM_FILTERS),
        .MAX_ELEMS     (MAX_ELEMS),
        .ELEM_PER_BEAT (ELEM_PER_BEAT)
    ) u_loader (
        .clk         (clk),
        .rst         (rst),
        .active      (state_reg == ST_LOAD_W),
        .n_filt      (nfilt_reg),
        .n_elem      (nelem_reg),
        .w_valid_i   (w_valid_i),
        .w_ready_o   (w_ready_o),
        .weight_en_o (weight_en_o),
        .load_done   (load_done)
    );

endmodule

// File: tb/tb_cnn_layer_ctrl.sv
// Self-checking bench for cnn_layer_ctrl: directed and randomized layers
// checked cycle by cycle against expectations derived from beat counts,
// phase lengths and sticky-flag rules.
module tb_cnn_layer_ctrl;

    localparam int NF   = 32;
    localparam int EPB  = 2;
    localparam int FILL = 68;
    localparam int LEAD = 16;
    localparam int FW   = $clog2(NF + 1);
    localparam int EW   = $clog2(63 + 1);
    localparam int OPW  = 3 + FW + EW;

    logic          clk = 1'b0;
    logic          rst, start_i, abort_i, w_valid_i;
    logic [OPW-1:0] op_code_i;
    logic          pu_finish_i, conv_finish_i, pool_finish_i, fc_finish_i;
    logic          w_ready_o, pu_en_o, conv_ctrl_o, pool_ctrl_o, fc_ctrl_o;
    logic          busy_o, done_o, err_o;
    logic [NF-1:0] weight_en_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cnn_layer_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .op_code_i     (op_code_i),
        .w_valid_i     (w_valid_i),
        .w_ready_o     (w_ready_o),
        .weight_en_o   (weight_en_o),
        .pu_en_o       (pu_en_o),
        .conv_ctrl_o   (conv_ctrl_o),
        .pool_ctrl_o   (pool_ctrl_o),
        .fc_ctrl_o     (fc_ctrl_o),
        .pu_finish_i   (pu_finish_i),
        .conv_finish_i (conv_finish_i),
        .pool_finish_i (pool_finish_i),
        .fc_finish_i   (fc_finish_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OPW-1:0] mk_op(input logic [2:0] m, input int nf, input int ne);
        logic [FW-1:0] f;
        logic [EW-1:0] e;
        f = FW'(nf);
        e = EW'(ne);
        return {e, f, m};
    endfunction

    task automatic clr_fin();
        pu_finish_i   = 1'b0;
        conv_finish_i = 1'b0;
        pool_finish_i = 1'b0;
        fc_finish_i   = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        #3;
        chk(tag, 64'({busy_o, done_o, err_o, w_ready_o, pu_en_o, conv_ctrl_o, pool_ctrl_o, fc_ctrl_o}), 64'(0));
        chk({tag, "_wen"}, 64'(weight_en_o), 64'(0));
    endtask

    task automatic do_start(input logic [2:0] m, input int nf, input int ne);
        op_code_i = mk_op(m, nf, ne);
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        op_code_i = OPW'($urandom);
    endtask

    // Expected filter = accepted beats / beats-per-filter.
    task automatic load_phase(input int nf, input int ne, input int vsel);
        int bpf, total, beats, guard;
        logic [NF-1:0] exp_we;
        bpf   = (ne + EPB - 1) / EPB;
        total = nf * bpf;
        beats = 0;
        guard = 0;
        while (beats < total && guard < 4000) begin
            case (vsel)
                0:       w_valid_i = 1'b1;
                1:       w_valid_i = (guard % 2 == 0);
                default: w_valid_i = 1'($urandom_range(0, 1));
            endcase
            #3;
            exp_we = '0;
            exp_we[beats / bpf] = 1'b1;
            chk("load_wen", 64'(weight_en_o), 64'(exp_we));
            chk("load_ready", 64'(w_ready_o), 64'(1));
            chk("load_pu_en", 64'(pu_en_o), 64'(0));
            tick();
            if (w_valid_i) beats++;
            guard++;
        end
        w_valid_i = 1'b0;
        chk("load_beats", 64'(beats), 64'(total));
    endtask

    // Returns 1 if aborted at cycle abort_at.
    task automatic fill_phase(input int abort_at, output logic aborted);
        aborted = 1'b0;
        for (int i = 0; i < FILL; i++) begin
            if (i == abort_at) begin
                abort_i = 1'b1;
                #3;
                chk("abort_fill_pu", 64'(pu_en_o), 64'(1));
                tick();
                abort_i = 1'b0;
                idle_check("abort_idle");
                aborted = 1'b1;
                return;
            end
            #3;
            chk("fill_pu", 64'(pu_en_o), 64'(1));
            chk("fill_conv", 64'(conv_ctrl_o), 64'(0));
            chk("fill_ready", 64'(w_ready_o), 64'(0));
            tick();
        end
    endtask

    task automatic done_check(input string tag);
        clr_fin();
        #3;
        chk({tag, "_done"}, 64'({done_o, busy_o, pu_en_o, conv_ctrl_o}), 64'(4'b1100));
        tick();
        #3;
        chk({tag, "_after"}, 64'({done_o, busy_o, err_o}), 64'(0));
    endtask

    task automatic conv_phase();
        int n;
        logic pu_flag;
        n = int'($urandom_range(0, 10));
        pu_flag = 1'b0;
        for (int i = 0; i <= n; i++) begin
            pu_finish_i   = ($urandom_range(0, 3) == 0);
            pool_finish_i = 1'($urandom_range(0, 1));
            fc_finish_i   = 1'($urandom_range(0, 1));
            conv_finish_i = (i == n);
            #3;
            chk("conv_pu", 64'(pu_en_o), 64'(!(pu_flag || pu_finish_i)));
            chk("conv_ctrl", 64'(conv_ctrl_o), 64'(!conv_finish_i));
            chk("conv_pool_fc", 64'({pool_ctrl_o, fc_ctrl_o}), 64'(0));
            tick();
            if (pu_finish_i) pu_flag = 1'b1;
        end
        done_check("conv");
    endtask

    task automatic fc_phase();
        int n;
        n = int'($urandom_range(0, 6));
        for (int i = 0; i <= n; i++) begin
            clr_fin();
            pool_finish_i = 1'($urandom_range(0, 1));
            fc_finish_i   = (i == n);
            #3;
            chk("fc_ctrl", 64'({fc_ctrl_o, pool_ctrl_o, conv_ctrl_o, pu_en_o}), 64'(4'b1000));
            tick();
        end
        done_check("fc");
    endtask

    // CONV lead then POOL, optionally FC; rst_at >= 0 resets during POOL.
    task automatic pool_phase(input logic has_fc, input int pu_at, input int rst_at);
        int cv_at, n;
        logic pu_flag, cv_flag;
        cv_at   = int'($urandom_range(0, LEAD + 4));
        pu_flag = 1'b0;
        cv_flag = 1'b0;
        for (int i = 0; i < LEAD; i++) begin
            pu_finish_i   = (i == pu_at);
            conv_finish_i = (i == cv_at);
            pool_finish_i = 1'($urandom_range(0, 1));
            fc_finish_i   = 1'($urandom_range(0, 1));
            #3;
            chk("lead_pu", 64'(pu_en_o), 64'(!(pu_flag || pu_finish_i)));
            chk("lead_conv", 64'(conv_ctrl_o), 64'(!(cv_flag || conv_finish_i)));
            chk("lead_pool", 64'({pool_ctrl_o, fc_ctrl_o}), 64'(0));
            tick();
            if (pu_finish_i)   pu_flag = 1'b1;
            if (conv_finish_i) cv_flag = 1'b1;
        end
        n = int'($urandom_range(0, 8));
        for (int i = 0; i <= n; i++) begin
            clr_fin();
            if (i == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                idle_check("rst_pool");
                return;
            end
            pu_finish_i   = ($urandom_range(0, 3) == 0);
            conv_finish_i = ($urandom_range(0, 3) == 0);
            pool_finish_i = (i == n);
            #3;
            chk("pool_ctrl", 64'({pool_ctrl_o, fc_ctrl_o}), 64'(2'b10));
            chk("pool_pu", 64'(pu_en_o), 64'(!(pu_flag || pu_finish_i)));
            chk("pool_conv", 64'(conv_ctrl_o), 64'(!(cv_flag || conv_finish_i)));
            tick();
            if (pu_finish_i)   pu_flag = 1'b1;
            if (conv_finish_i) cv_flag = 1'b1;
        end
        if (has_fc) fc_phase();
        else        done_check("pool");
    endtask

    task automatic err_case(input string tag, input logic [2:0] m, input int nf, input int ne);
        do_start(m, nf, ne);
        #3;
        chk({tag, "_err"}, 64'({err_o, busy_o}), 64'(2'b10));
        tick();
        #3;
        chk({tag, "_clr"}, 64'({err_o, busy_o}), 64'(0));
    endtask

    initial begin
        logic ab;
        int nf, ne;
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; w_valid_i = 1'b0;
        op_code_i = '0;
        clr_fin();
        repeat (3) tick();
        rst = 1'b0;
        idle_check("reset");

        // conv, 3 filters x 9 elements, valid always high
        do_start(3'b001, 3, 9);
        load_phase(3, 9, 0);
        fill_phase(-1, ab);
        conv_phase();

        // conv with toggling valid
        do_start(3'b001, 2, 9);
        load_phase(2, 9, 1);
        fill_phase(-1, ab);
        conv_phase();

        // conv_pool_fc with pu_finish during CONV
        do_start(3'b110, 2, 5);
        load_phase(2, 5, 2);
        fill_phase(-1, ab);
        pool_phase(1'b1, 5, -1);

        // conv_pool, single element: partial final beat
        do_start(3'b010, 1, 1);
        load_phase(1, 1, 0);
        fill_phase(-1, ab);
        pool_phase(1'b0, 0, -1);

        // rejected starts
        err_case("ill100", 3'b100, 1, 4);
        err_case("ill101", 3'b101, 1, 4);
        err_case("nfilt33", 3'b001, 33, 4);
        err_case("nfilt0", 3'b010, 0, 4);
        err_case("nelem0", 3'b110, 2, 0);

        // nop: no error, no transition
        do_start(3'b000, 1, 1);
        #3;
        chk("nop", 64'({err_o, busy_o}), 64'(0));

        // fc only: filter/element fields are not constrained
        tick();
        do_start(3'b011, 0, 0);
        fc_phase();

        // abort in FILL cycle 10
        do_start(3'b001, 1, 4);
        load_phase(1, 4, 0);
        fill_phase(10, ab);
        chk("abort_taken", 64'(ab), 64'(1));

        // rst during POOL
        do_start(3'b010, 2, 3);
        load_phase(2, 3, 2);
        fill_phase(-1, ab);
        pool_phase(1'b0, 99, 0);

        // full clean run after reset, all NF filters
        do_start(3'b110, NF, 2);
        load_phase(NF, 2, 0);
        fill_phase(-1, ab);
        pool_phase(1'b1, 3, -1);

        // flush, with a start attempted while busy
        do_start(3'b111, 0, 0);
        op_code_i = mk_op(3'b001, 1, 2);
        start_i   = 1'b1;
        #3;
        chk("flush_done", 64'({busy_o, done_o}), 64'(2'b11));
        tick();
        start_i = 1'b0;
        #3;
        chk("flush_after", 64'({busy_o, done_o, err_o}), 64'(0));
        tick();
        #3;
        chk("busy_start_ignored", 64'(busy_o), 64'(0));

        // illegal start while in LOAD_W is ignored
        tick();
        do_start(3'b001, 1, 8);
        op_code_i = mk_op(3'b100, 1, 1);
        start_i   = 1'b1;
        #3;
        chk("ldw_start_wen", 64'(weight_en_o), 64'(1));
        tick();
        start_i = 1'b0;
        #3;
        chk("ldw_start_ign", 64'({err_o, busy_o}), 64'(2'b01));
        load_phase(1, 8, 2);
        fill_phase(-1, ab);
        conv_phase();

        // abort and start together in IDLE: abort wins
        op_code_i = mk_op(3'b001, 1, 2);
        start_i   = 1'b1;
        abort_i   = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        idle_check("abort_start");

        // randomized layers
        for (int k = 0; k < 4; k++) begin
            nf = int'($urandom_range(1, 4));
            ne = int'($urandom_range(1, 63));
            case ($urandom_range(0, 2))
                0: begin
                    do_start(3'b001, nf, ne);
                    load_phase(nf, ne, 2);
                    fill_phase(-1, ab);
                    conv_phase();
                end
                1: begin
                    do_start(3'b010, nf, ne);
                    load_phase(nf, ne, 2);
                    fill_phase(-1, ab);
                    pool_phase(1'b0, int'($urandom_range(0, 20)), -1);
                end
                default: begin
                    do_start(3'b110, nf, ne);
                    load_phase(nf, ne, 2);
                    fill_phase(-1, ab);
                    pool_phase(1'b1, int'($urandom_range(0, 20)), -1);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
